// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 requesters.
// Grants are held until release, request drop, or hold timeout.
module mux_rr_arbiter #(
  parameter int NREQ     = 8,
  parameter int SELW     = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            rel,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_d;
  logic [SELW-1:0]   sel_d;
  logic              gv_d;
  logic              to_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [SELW-1:0]   win;
  logic [SELW-1:0]   idx;
  logic              found;
  logic              rel_hit;
  logic              to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      sel       <= sel_d;
      gnt_valid <= gv_d;
      timeout   <= to_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    sel_d   = sel;
    gv_d    = gnt_valid;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win     = ptr_q;
    idx     = ptr_q;
    found   = 1'b0;
    rel_hit = 1'b0;
    to_hit  = 1'b0;

    // circular search starting at the priority pointer
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + SELW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = NREQ'(1) << win;
          sel_d   = win;
          gv_d    = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        rel_hit = rel || !req[sel];
        to_hit  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
        if (rel_hit || to_hit) begin
          grant_d = '0;
          gv_d    = 1'b0;
          ptr_d   = sel + SELW'(1);
          cnt_d   = '0;
          state_d = IDLE;
          to_d    = to_hit && !rel_hit;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: vector table plus
// hand-written timeout and coincident-release sequences.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       t;
  } vec_t;

  vec_t vecs[$];

  mux_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .grant     (grant),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int step,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, step, act, exp);
    end
  endtask

  task automatic step(input int n, input logic r, input logic [7:0] q,
                      input logic l, input logic [7:0] g,
                      input logic [2:0] s, input logic v, input logic t);
    rst = r;
    req = q;
    rel = l;
    @(posedge clk);
    #1;
    chk("grant", n, grant, g);
    chk("sel", n, {5'd0, sel}, {5'd0, s});
    chk("gnt_valid", n, {7'd0, gnt_valid}, {7'd0, v});
    chk("timeout", n, {7'd0, timeout}, {7'd0, t});
  endtask

  function automatic void add(input logic r, input logic [7:0] q,
                              input logic l, input logic [7:0] g,
                              input logic [2:0] s, input logic v,
                              input logic t);
    vec_t x;
    x.rst = r; x.req = q; x.rel = l;
    x.g = g; x.s = s; x.v = v; x.t = t;
    vecs.push_back(x);
  endfunction

  initial begin
    int own[4];
    own[0] = 1; own[1] = 2; own[2] = 7; own[3] = 1;

    // basic rotation: req=86, rel on the 3rd grant cycle
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    foreach (own[k]) begin
      for (int c = 0; c < 3; c++)
        add(0, 8'h86, 0, 8'h01 << own[k], 3'(own[k]), 1, 0);
      add(0, 8'h86, 1, 8'h00, 3'(own[k]), 0, 0);
    end

    // full-load fairness: rel on the first grant cycle
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int o = 0; o < 9; o++) begin
      add(0, 8'hFF, 0, 8'h01 << (o % 8), 3'(o % 8), 1, 0);
      add(0, 8'hFF, 1, 8'h00, 3'(o % 8), 0, 0);
    end
    add(0, 8'h00, 0, 8'h00, 0, 0, 0);

    // implicit release by owner 5; 6 must beat 4 afterwards
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 8'h20, 0, 8'h20, 5, 1, 0);
    add(0, 8'h20, 0, 8'h20, 5, 1, 0);
    add(0, 8'h50, 0, 8'h00, 5, 0, 0);
    add(0, 8'h50, 0, 8'h40, 6, 1, 0);
    add(0, 8'h50, 1, 8'h00, 6, 0, 0);

    // reset mid-grant, then 0 before 7
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 8'h08, 0, 8'h08, 3, 1, 0);
    add(0, 8'h08, 0, 8'h08, 3, 1, 0);
    add(1, 8'h08, 0, 8'h00, 0, 0, 0);
    add(0, 8'h81, 0, 8'h01, 0, 1, 0);
    add(0, 8'h81, 1, 8'h00, 0, 0, 0);
    add(0, 8'h81, 0, 8'h80, 7, 1, 0);

    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      step(i, vecs[i].rst, vecs[i].req, vecs[i].rel,
           vecs[i].g, vecs[i].s, vecs[i].v, vecs[i].t);

    // timeout: 16 grant cycles, pulse, one idle, re-grant
    step(1000, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 16; c++)
      step(1001 + c, 0, 8'h10, 0, 8'h10, 4, 1, 0);
    step(1017, 0, 8'h10, 0, 8'h00, 4, 0, 1);
    step(1018, 0, 8'h10, 0, 8'h10, 4, 1, 0);

    // rel in the 16th grant cycle suppresses the timeout pulse
    for (int c = 0; c < 15; c++)
      step(1019 + c, 0, 8'h10, 0, 8'h10, 4, 1, 0);
    step(1034, 0, 8'h10, 1, 8'h00, 4, 0, 0);
    step(1035, 0, 8'h00, 0, 8'h00, 4, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
